// File: rtl/mc_control.sv
// Multi-cycle MIPS controller: sequences FETCH/DECODE/EXE/MEM/WB/HALT for
// addu, subu, ori, lui, lw, sw, beq, jal, jr and nop. It adds a data-memory
// ready handshake with a bounded wait, illegal-instruction flagging and a
// retired-instruction counter.
module mc_control #(
  parameter int ALUOP_W      = 4,
  parameter int CNT_W        = 32,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         OpCode,
  input  logic [5:0]         Func,
  input  logic               dmem_ready,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic [1:0]         NPCOp,
  output logic               RegWrite,
  output logic [1:0]         EXTOp,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [1:0]         AluBSel,
  output logic               MemRead,
  output logic               MemWrite,
  output logic [1:0]         RegA3Sel,
  output logic [1:0]         RegDataSel,
  output logic [2:0]         state,
  output logic               illegal,
  output logic               bus_error,
  output logic [CNT_W-1:0]   retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  // Opcode / function field encodings of the supported subset.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_NOP   = 6'b000000;

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(2);

  // Wait-counter value seen in the MEM cycle that would reach the limit.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

  state_t             state_q, state_d;
  logic [7:0]         wait_q, wait_d;
  logic               bus_error_q, bus_error_d;
  logic [CNT_W-1:0]   retired_q, retired_d;

  // Raw strobes before the reset override.
  logic ir_raw, pcw_raw, rw_raw, mr_raw, mw_raw, ill_raw;

  // Instruction decode flags.
  logic is_rtype, is_addu, is_subu, is_jr, is_nop;
  logic is_ori, is_lui, is_lw, is_sw, is_beq, is_jal;
  logic is_legal;

  // Classify the IR fields into one-hot instruction flags.
  always_comb begin
    is_rtype = (OpCode == OP_RTYPE);
    is_addu  = is_rtype && (Func == FN_ADDU);
    is_subu  = is_rtype && (Func == FN_SUBU);
    is_jr    = is_rtype && (Func == FN_JR);
    is_nop   = is_rtype && (Func == FN_NOP);
    is_ori   = (OpCode == OP_ORI);
    is_lui   = (OpCode == OP_LUI);
    is_lw    = (OpCode == OP_LW);
    is_sw    = (OpCode == OP_SW);
    is_beq   = (OpCode == OP_BEQ);
    is_jal   = (OpCode == OP_JAL);
    is_legal = is_addu | is_subu | is_jr | is_nop |
               is_ori | is_lui | is_lw | is_sw | is_beq | is_jal;
  end

  // Datapath selects depend only on the instruction, so they stay constant
  // for the whole EXE/MEM/WB span while the IR holds the instruction.
  always_comb begin
    EXTOp      = 2'b00;
    ALUOp      = ALU_ADD;
    AluBSel    = 2'b00;
    RegA3Sel   = 2'b00;
    RegDataSel = 2'b00;
    NPCOp      = 2'b00;
    if (is_subu) begin
      ALUOp = ALU_SUB;
    end
    if (is_beq) begin
      ALUOp = ALU_SUB;
      NPCOp = 2'b01;
    end
    if (is_ori) begin
      ALUOp    = ALU_OR;
      EXTOp    = 2'b00;
      AluBSel  = 2'b01;
      RegA3Sel = 2'b01;
    end
    if (is_lui) begin
      EXTOp      = 2'b10;
      RegA3Sel   = 2'b01;
      RegDataSel = 2'b10;
    end
    if (is_lw || is_sw) begin
      ALUOp   = ALU_ADD;
      EXTOp   = 2'b01;
      AluBSel = 2'b01;
    end
    if (is_lw) begin
      RegA3Sel   = 2'b01;
      RegDataSel = 2'b01;
    end
    if (is_jal) begin
      RegA3Sel   = 2'b10;
      RegDataSel = 2'b11;
      NPCOp      = 2'b10;
    end
    if (is_jr) begin
      NPCOp = 2'b11;
    end
  end

  // Next-state, per-state strobes and the MEM wait/timeout bookkeeping.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    bus_error_d = bus_error_q;
    ir_raw      = 1'b0;
    pcw_raw     = 1'b0;
    rw_raw      = 1'b0;
    mr_raw      = 1'b0;
    mw_raw      = 1'b0;
    ill_raw     = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_raw  = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_nop || !is_legal) begin
          pcw_raw = 1'b1;
          ill_raw = !is_legal;
          state_d = S_FETCH;
        end else if (is_jal) begin
          state_d = S_WB;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        wait_d = 8'd0;
        if (is_beq || is_jr) begin
          pcw_raw = 1'b1;
          state_d = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mr_raw = is_lw;
        mw_raw = is_sw;
        if (dmem_ready) begin
          // Ready wins even in the cycle the wait limit would be reached.
          wait_d = 8'd0;
          if (is_sw) begin
            pcw_raw = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q == WAIT_LAST) begin
          wait_d      = 8'd0;
          bus_error_d = 1'b1;
          state_d     = S_HALT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WB: begin
        rw_raw  = 1'b1;
        pcw_raw = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Strobes are forced low while reset is asserted.
  always_comb begin
    IRWrite  = ir_raw  & ~reset;
    PCWrite  = pcw_raw & ~reset;
    RegWrite = rw_raw  & ~reset;
    MemRead  = mr_raw  & ~reset;
    MemWrite = mw_raw  & ~reset;
    illegal  = ill_raw & ~reset;
  end

  // Retired count advances once per instruction, in its PCWrite cycle.
  always_comb begin
    retired_d = PCWrite ? (retired_q + CNT_W'(1)) : retired_q;
  end

  // State, wait counter, sticky bus error and retired counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      wait_q      <= 8'd0;
      bus_error_q <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      bus_error_q <= bus_error_d;
      retired_q   <= retired_d;
    end
  end

  assign state     = state_q;
  assign bus_error = bus_error_q;
  assign retired   = retired_q;

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multi-cycle successor to the single-cycle MIPS decoder/controller.
- Drives the shared datapath through the states FETCH, DECODE, EXE, MEM, WB and HALT for the subset: addu, subu, ori, lui, lw, sw, beq, jal, jr, nop.
- Adds a data-memory ready handshake with timeout, illegal-instruction flagging and a retired-instruction counter.
- Sits between the IR (OpCode/Func fields) and the datapath mux/strobe controls.

Parameters:
- ALUOP_W, 4: width of ALUOp. Encodings: 0 add, 1 sub, 2 or.
- CNT_W, 32: width of the retired-instruction counter.
- MEM_WAIT_MAX, 15: maximum cycles spent in MEM without dmem_ready before a bus error. Legal range 1..255.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- OpCode  in  6  IR[31:26].
- Func  in  6  IR[5:0].
- dmem_ready  in  1  data memory has completed the access this cycle.
- IRWrite  out  1  load IR.
- PCWrite  out  1  load PC with NPC.
- NPCOp  out  2  00 PC+4; 01 beq target if ALU zero, else PC+4; 10 jal target; 11 GPR[rs].
- RegWrite  out  1  register file write enable.
- EXTOp  out  2  00 zero-extend; 01 sign-extend; 10 lui (imm<<16).
- ALUOp  out  ALUOP_W  ALU operation.
- AluBSel  out  2  00 GPR[rt]; 01 extended immediate.
- MemRead  out  1  data memory read request.
- MemWrite  out  1  data memory write request.
- RegA3Sel  out  2  00 rd; 01 rt; 10 $31.
- RegDataSel  out  2  00 ALU result; 01 memory data; 10 extended immediate; 11 PC+4.
- state  out  3  FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4, HALT=5.
- illegal  out  1  one-cycle pulse in DECODE on an unsupported encoding.
- bus_error  out  1  sticky until reset.
- retired  out  CNT_W  count of PCWrite cycles; wraps to 0 at 2^CNT_W-1.

Behaviour:
- Reset:
  - Synchronous: state<=FETCH, retired<=0, bus_error<=0, wait counter<=0.
  - While reset is high, every strobe output (IRWrite, PCWrite, RegWrite, MemRead, MemWrite, illegal) is forced to 0.
  - Reset mid-instruction abandons the instruction. No write strobe is asserted in the reset cycle.
- Output timing:
  - Strobe and mux outputs are combinational from state, OpCode and Func (Moore-per-state).
  - Datapath selects (EXTOp, AluBSel, ALUOp) are held constant across EXE/MEM/WB of one instruction.
- FETCH: IRWrite=1; next state DECODE.
- DECODE transitions:
  - nop or illegal: PCWrite=1, NPCOp=00; next FETCH. illegal=1 for illegal encodings. Total 2 cycles.
  - jal: next WB.
  - All other legal instructions: next EXE.
- EXE transitions:
  - beq: ALUOp=sub, AluBSel=00, PCWrite=1, NPCOp=01; next FETCH. Total 3 cycles.
  - jr: PCWrite=1, NPCOp=11; next FETCH. Total 3 cycles.
  - addu/subu: ALUOp add/sub, AluBSel=00; next WB.
  - ori: ALUOp=or, EXTOp=00, AluBSel=01; next WB.
  - lui: EXTOp=10; next WB.
  - lw/sw: ALUOp=add, EXTOp=01, AluBSel=01; next MEM.
- MEM:
  - MemRead (lw) or MemWrite (sw) is held high every MEM cycle until dmem_ready=1.
  - lw + ready: next WB.
  - sw + ready: PCWrite=1, NPCOp=00; next FETCH.
  - The wait counter increments each MEM cycle without ready.
  - If the count reaches MEM_WAIT_MAX without ready: bus_error<=1, next HALT, no PCWrite.
  - If ready arrives in the same cycle the limit is reached, ready wins.
- WB:
  - RegWrite=1 and PCWrite=1 in the same cycle.
  - addu/subu: A3=00, Data=00.
  - ori: A3=01, Data=00.
  - lui: A3=01, Data=10.
  - lw: A3=01, Data=01.
  - jal: A3=10, Data=11, NPCOp=10.
  - All others: NPCOp=00.
  - Next FETCH.
- HALT: all strobes 0; remains in HALT until reset.
- Decode rules:
  - R-type (OpCode 000000) is decoded by Func: 100001 addu, 100011 subu, 001000 jr, 000000 nop.
  - Any other Func, or any unlisted OpCode, is illegal.
- Cycle counts: nop 2; beq/jr/jal 3; ALU ops 4; sw 4+waits; lw 5+waits.
- retired increments exactly once per instruction, in the PCWrite cycle.

Test Plan:
- Reset asserted for 2 cycles during lw's MEM state: next cycle state=0, retired=0, MemRead=0, no RegWrite.
- Sequence ori, addu, beq, jal, jr (dmem_ready don't-care) → state traces 0,1,2,4 | 0,1,2,4 | 0,1,2 | 0,1,4 | 0,1,2; retired=5 after 17 cycles. jal WB shows RegA3Sel=10, RegDataSel=11, NPCOp=10.
- lw with dmem_ready asserted on the 3rd MEM cycle → MemRead high for exactly 3 cycles, then WB with RegDataSel=01, RegA3Sel=01; instruction takes 7 cycles.
- sw with dmem_ready never asserted, MEM_WAIT_MAX=4 → MemWrite high for 4 cycles, then bus_error=1, state=5, PCWrite never asserted; stays halted until reset.
- OpCode=6'b111111 → illegal pulses for 1 cycle in DECODE, PCWrite=1 with NPCOp=00, retired increments by 1, no RegWrite.
- CNT_W=4: execute 17 nops → retired wraps 15→0 and reads 1 at the end.
